// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - push-button synchronizer, debouncer and one-hot press arbiter
module pb_conditioner #(
  parameter int DEB_CYCLES = 100000,
  parameter int CNT_W      = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] pb_raw,
  output logic [6:0] keys,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {IDLE, HELD, LOCK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [6:0]       sync1, sync2;
  logic [6:0]       deb;
  logic [CNT_W-1:0] cnt [7];
  state_t           state;
  logic             deb_onehot;

  assign deb_onehot = (deb != 7'h00) && ((deb & (deb - 7'd1)) == 7'h00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 7'h00;
      sync2 <= 7'h00;
    end else begin
      sync1 <= pb_raw;
      sync2 <= sync1;
    end
  end

  // Each bit only flips after DEB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb <= 7'h00;
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      keys      <= 7'h00;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      keys      <= 7'h00;
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (deb_onehot) begin
            keys      <= deb;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else if (deb != 7'h00) begin
            key_held  <= 1'b1;
            state     <= LOCK;
          end else begin
            key_held  <= 1'b0;
          end
        end
        HELD, LOCK: begin
          if (deb == 7'h00) begin
            key_held <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          key_held <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// tb/tb_pb_conditioner.sv - scoreboard bench for pb_conditioner with DEB_CYCLES = 4
module tb_pb_conditioner;

  localparam int D = 4;

  typedef struct {
    logic [6:0] k;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] pb_raw = 7'h00;
  logic [6:0] keys;
  logic       key_valid;
  logic       key_held;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb [$];

  pb_conditioner #(.DEB_CYCLES(D), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_raw    (pb_raw),
    .keys      (keys),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A press driven now is first seen at the next edge and reported 6 edges after that.
  task automatic press(input logic [6:0] v);
    exp_t e;
    pb_raw = v;
    e.k    = v;
    e.cyc  = cyc + 3 + D;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (key_valid) begin
      check("onehot", 32'(keys & (keys - 7'd1)), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(keys), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_keys", 32'(keys), 32'(e.k));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("idle_keys", 32'(keys), 32'd0);
    end
  end

  initial begin
    int c0;
    int total;
    int p;
    logic lvl;

    // Reset with every button down
    pb_raw = 7'h7F;
    rst_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_keys", 32'(keys), 32'd0);
      check("rst_valid", 32'(key_valid), 32'd0);
      check("rst_held", 32'(key_held), 32'd0);
    end
    pb_raw = 7'h00;
    step(1);
    rst_n = 1'b1;
    step(10);

    // Single press and release timing
    press(7'h10);
    step(12);
    check("single_held", 32'(key_held), 32'd1);
    pb_raw = 7'h00;
    c0 = cyc;
    step(6);
    check("release_held_late", 32'(key_held), 32'd1);
    check("release_cyc", 32'(cyc - c0), 32'd6);
    step(1);
    check("release_held_drop", 32'(key_held), 32'd0);
    step(5);

    // Bounce: runs of 1..3 cycles never survive the debouncer
    lvl = 1'b1;
    total = 0;
    while (total < 20) begin
      pb_raw = {lvl, 6'h00};
      p = $urandom_range(1, 3);
      step(p);
      total += p;
      lvl = ~lvl;
    end
    if (lvl == 1'b0) begin
      pb_raw = 7'h00;
      step(1);
    end
    press(7'h40);
    step(12);
    pb_raw = 7'h00;
    step(12);
    check("bounce_held_clear", 32'(key_held), 32'd0);

    // Chord locks out, then a clean single press
    pb_raw = 7'h41;
    step(8);
    check("chord_held", 32'(key_held), 32'd1);
    pb_raw = 7'h00;
    step(10);
    check("chord_release", 32'(key_held), 32'd0);
    press(7'h01);
    step(10);
    pb_raw = 7'h00;
    step(10);

    // Staggered second key is ignored
    press(7'h08);
    step(2);
    pb_raw = 7'h0C;
    step(12);
    check("stagger_held", 32'(key_held), 32'd1);
    pb_raw = 7'h00;
    step(10);
    press(7'h04);
    step(10);
    pb_raw = 7'h00;
    step(10);

    // Reset mid-press, button stays down and is reported again
    press(7'h02);
    step(10);
    check("mid_held", 32'(key_held), 32'd1);
    rst_n = 1'b0;
    step(2);
    check("mid_rst_held", 32'(key_held), 32'd0);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    begin
      exp_t e;
      rst_n = 1'b1;
      e.k   = 7'h02;
      e.cyc = cyc + 3 + D;
      sb.push_back(e);
    end
    step(12);
    check("mid_repress_held", 32'(key_held), 32'd1);
    pb_raw = 7'h00;
    step(12);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_conditioner.md
# pb_conditioner

Front-end conditioner for the seven note push-buttons. It synchronizes and debounces the raw button inputs and arbitrates simultaneous presses. For each accepted press it emits exactly one single-cycle, one-hot key vector. Sits directly upstream of `pb_decoder`: its `keys` output drives the decoder's `keys` input, which is all-zero except during the one-cycle press event.

## Interface

- `DEB_CYCLES`, default 100000 — consecutive stable cycles required to accept a level change (1 ms at 100 MHz); legal range 2..2^CNT_W−1.
- `CNT_W`, default 17 — width of each debounce counter.
- `clk` input 1 — single system clock; all state updates on rising edge.
- `rst_n` input 1 — reset, synchronous, active-low.
- `pb_raw` input 7 — raw buttons, active-high, asynchronous to `clk`; bit 6 = key A … bit 0 = key G.
- `keys` output 7 — registered; one-hot copy of the accepted key for exactly one cycle, else 7'h00.
- `key_valid` output 1 — registered; high in the same cycle `keys` is non-zero.
- `key_held` output 1 — registered; high while an accepted key (or locked-out chord) is still down.

## Operation

- Synchronizer: each `pb_raw` bit passes through 2 flip-flops (`sync`).
- Debounce, per bit: a debounced register `deb[i]` and counter `cnt[i]`.
  - If `sync[i] == deb[i]`: `cnt[i]` clears to 0.
  - Otherwise `cnt[i]` increments. When `cnt[i] == DEB_CYCLES−1` and the mismatch persists, `deb[i]` takes `sync[i]` and `cnt[i]` clears.
  - A glitch shorter than `DEB_CYCLES` cycles never changes `deb`.
- Arbiter FSM on the 7-bit `deb` vector; states IDLE, HELD, LOCK.
  - IDLE, `deb == 0`: stay.
  - IDLE, `deb` exactly one-hot: register `keys = deb`, `key_valid = 1`; go to HELD.
  - IDLE, ≥2 bits set (chord): no output; go to LOCK.
  - HELD: `keys = 0`, `key_valid = 0`. Further presses are ignored. Return to IDLE when `deb == 0`.
  - LOCK: same outputs as HELD. Return to IDLE when `deb == 0`.
- `key_held` = 1 in HELD and LOCK, 0 in IDLE.
- Reset (`rst_n` low at an edge): `sync`, `deb`, `cnt` = 0; state = IDLE; `keys` = 7'h00, `key_valid` = 0, `key_held` = 0. Reset mid-press aborts everything.
- A button still held when reset releases is re-debounced from `deb = 0` and reported as a new press.

## Timing

- Press latency: `pb_raw[i]` rises before edge k and stays stable.
  - `sync[i]` = 1 after edge k+1.
  - `deb[i]` = 1 after edge k+1+DEB_CYCLES.
  - `keys`/`key_valid` = 1 after edge k+2+DEB_CYCLES, for exactly one cycle.
- Release latency: `deb` returns to 0 DEB_CYCLES+2 cycles after `pb_raw` falls. The state returns to IDLE on the next edge, dropping `key_held`.
- The earliest next `key_valid` is one cycle after returning to IDLE, plus the new press's debounce time.
- Simultaneous events:
  - Two bits reaching `deb` in the same cycle is a chord → LOCK.
  - Staggered by ≥1 cycle: the first key is emitted and the second is ignored.
- `keys` is never non-zero outside a `key_valid` cycle and is never multi-hot.

## Test plan

Run with `DEB_CYCLES` = 4.

1. Reset: hold `rst_n` = 0 for 3 cycles with `pb_raw` = 7'h7F → `keys` = 0, `key_valid` = 0, `key_held` = 0 throughout reset.
2. Single press: `pb_raw` = 7'h10 steady from edge 0 → `keys` = 7'h10 with `key_valid` = 1 for exactly one cycle after edge 6. `key_held` stays 1 until 7 cycles after release.
3. Bounce: toggle `pb_raw[6]` with periods of 1–3 cycles for 20 cycles, then hold at 1 → exactly one `keys` = 7'h40 pulse, 6 cycles after the final stable edge.
4. Chord: `pb_raw` = 7'h41 on the same edge → no `key_valid` pulse, `key_held` = 1. After release, pressing 7'h01 alone → a single 7'h01 pulse.
5. Staggered: 7'h08 at edge 0, then 7'h0C at edge 2 → one 7'h08 pulse only. After a full release, press 7'h04 → one 7'h04 pulse.
6. Reset mid-press: assert reset while `key_held` = 1 with the button still down, then release reset → all outputs 0, then a new `key_valid` pulse DEB_CYCLES+3 cycles after reset deasserts.
